// File: rtl/cpu_pkg.sv
// Shared control-phase encodings, opcode constants and sign-extension helper
// for the execute datapath and its ALU.
package cpu_pkg;

    localparam logic [2:0] ST_RESET = 3'b000;
    localparam logic [2:0] ST_EXEC  = 3'b010;
    localparam logic [2:0] ST_STORE = 3'b100;
    localparam logic [2:0] ST_DONE  = 3'b101;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SLL  = 4'h5;
    localparam logic [3:0] OP_SRL  = 4'h6;
    localparam logic [3:0] OP_ADDI = 4'h7;
    localparam logic [3:0] OP_SLT  = 4'h8;
    localparam logic [3:0] OP_LW   = 4'h9;
    localparam logic [3:0] OP_SW   = 4'hA;
    localparam logic [3:0] OP_BEQ  = 4'hB;
    localparam logic [3:0] OP_BNE  = 4'hC;
    localparam logic [3:0] OP_LI   = 4'hD;
    localparam logic [3:0] OP_J    = 4'hE;
    localparam logic [3:0] OP_JR   = 4'hF;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_RUN,
        DS_HOLD
    } dump_state_t;

    function automatic logic [15:0] sext(input logic [3:0] v);
        return {{12{v[3]}}, v};
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU and next-PC decision for one decoded instruction;
// also flags which instructions write back and which touch data RAM.
module exec_alu
    import cpu_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [3:0]  rs,
    input  logic [3:0]  rt,
    input  logic [15:0] rd_val,
    input  logic [15:0] rs_val,
    input  logic [15:0] rt_val,
    output logic [15:0] result,
    output logic [5:0]  pc_off,
    output logic [7:0]  mem_addr,
    output logic        wb_en,
    output logic        wb_mem,
    output logic        mem_we
);

    logic [15:0] eff_addr;

    assign eff_addr = rs_val + sext(rt);
    assign mem_addr = eff_addr[7:0];

    always_comb begin
        result = '0;
        pc_off = 6'd1;
        wb_en  = 1'b1;
        wb_mem = 1'b0;
        mem_we = 1'b0;
        case (opcode)
            OP_ADD:  result = rs_val + rt_val;
            OP_SUB:  result = rs_val - rt_val;
            OP_AND:  result = rs_val & rt_val;
            OP_OR:   result = rs_val | rt_val;
            OP_XOR:  result = rs_val ^ rt_val;
            OP_SLL:  result = rs_val << rt_val[3:0];
            OP_SRL:  result = rs_val >> rt_val[3:0];
            OP_ADDI: result = eff_addr;
            OP_SLT:  result = {15'd0, $signed(rs_val) < $signed(rt_val)};
            OP_LI:   result = {8'd0, rs, rt};
            OP_LW:   wb_mem = 1'b1;
            OP_SW: begin
                wb_en  = 1'b0;
                mem_we = 1'b1;
            end
            OP_BEQ: begin
                wb_en = 1'b0;
                if (rd_val == rs_val) pc_off = {{2{rt[3]}}, rt};
            end
            OP_BNE: begin
                wb_en = 1'b0;
                if (rd_val != rs_val) pc_off = {{2{rt[3]}}, rt};
            end
            OP_J: begin
                wb_en  = 1'b0;
                pc_off = {rs[1:0], rt};
            end
            OP_JR: begin
                wb_en  = 1'b0;
                pc_off = rs_val[5:0];
            end
            default: wb_en = 1'b0;
        endcase
    end

endmodule

// File: rtl/exec_datapath.sv
// Execute/store datapath: 16x16 register file, registered ALU results, RAM port
// and a register dump sequencer present only when EXEC_DATAPATH_DUMP_EN is defined.
//
// dump state | meaning
// DS_IDLE    | waiting for state=101; restart point after an abort
// DS_RUN     | presenting R[dump_idx], one register per cycle
// DS_HOLD    | all 16 registers dumped, dump_done held until reset
module exec_datapath
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  state,
    input  logic [3:0]  opcode,
    input  logic [3:0]  rd,
    input  logic [3:0]  rs,
    input  logic [3:0]  rt,
    output logic [5:0]  pc_off,
    output logic [7:0]  ram_addr,
    output logic [15:0] ram_wdata,
    output logic        ram_we,
    input  logic [15:0] ram_rdata,
    output logic        dump_valid,
    output logic [3:0]  dump_idx,
    output logic [15:0] dump_data,
    output logic        dump_done
);

    logic [15:0] rf [16];
    logic [15:0] rd_val, rs_val, rt_val;
    logic [15:0] alu_result;
    logic [5:0]  alu_pc_off;
    logic [7:0]  alu_addr;
    logic        alu_wb_en, alu_wb_mem, alu_mem_we;

    logic [15:0] result_q;
    logic [3:0]  wb_rd_q;
    logic        wb_en_q, wb_mem_q, ram_we_q;

    assign rd_val = (rd == 4'd0) ? 16'd0 : rf[rd];
    assign rs_val = (rs == 4'd0) ? 16'd0 : rf[rs];
    assign rt_val = (rt == 4'd0) ? 16'd0 : rf[rt];

    exec_alu u_alu (
        .opcode   (opcode),
        .rs       (rs),
        .rt       (rt),
        .rd_val   (rd_val),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .result   (alu_result),
        .pc_off   (alu_pc_off),
        .mem_addr (alu_addr),
        .wb_en    (alu_wb_en),
        .wb_mem   (alu_wb_mem),
        .mem_we   (alu_mem_we)
    );

    // Strobe is gated by the phase so it can never outlive the STORE cycle.
    assign ram_we = ram_we_q && (state == ST_STORE);

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) rf[i] <= '0;
            result_q  <= '0;
            pc_off    <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_we_q  <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_mem_q  <= 1'b0;
            wb_rd_q   <= '0;
        end else begin
            ram_we_q <= 1'b0;
            wb_en_q  <= 1'b0;
            if (state == ST_EXEC) begin
                result_q  <= alu_result;
                pc_off    <= alu_pc_off;
                ram_addr  <= alu_addr;
                ram_wdata <= rd_val;
                ram_we_q  <= alu_mem_we;
                wb_en_q   <= alu_wb_en;
                wb_mem_q  <= alu_wb_mem;
                wb_rd_q   <= rd;
            end
            if (state == ST_STORE && wb_en_q && wb_rd_q != 4'd0)
                rf[wb_rd_q] <= wb_mem_q ? ram_rdata : result_q;
        end
    end

`ifdef EXEC_DATAPATH_DUMP_EN
    dump_state_t dump_st;

    always_ff @(posedge clk) begin
        if (reset) begin
            dump_st    <= DS_IDLE;
            dump_valid <= 1'b0;
            dump_idx   <= '0;
            dump_data  <= '0;
            dump_done  <= 1'b0;
        end else begin
            case (dump_st)
                DS_IDLE: if (state == ST_DONE) begin
                    dump_st    <= DS_RUN;
                    dump_valid <= 1'b1;
                    dump_idx   <= 4'd0;
                    dump_data  <= rf[0];
                end
                DS_RUN: if (state != ST_DONE) begin
                    dump_st    <= DS_IDLE;
                    dump_valid <= 1'b0;
                end else if (dump_idx == 4'd15) begin
                    dump_st    <= DS_HOLD;
                    dump_valid <= 1'b0;
                    dump_done  <= 1'b1;
                end else begin
                    dump_idx  <= dump_idx + 4'd1;
                    dump_data <= rf[dump_idx + 4'd1];
                end
                DS_HOLD: dump_st <= DS_HOLD;
                default: dump_st <= DS_IDLE;
            endcase
        end
    end
`else
    assign dump_valid = 1'b0;
    assign dump_idx   = 4'd0;
    assign dump_data  = 16'd0;
    assign dump_done  = (state == ST_DONE);
`endif

endmodule
